// File: rtl/mem_axil_slave_if.sv
// AXI-Lite bus bundle between the core's memory master and mem_axil_slave.
interface mem_axil_slave_if #(
   parameter int unsigned WIDTH = 32
);
   logic [WIDTH-1:0]   s_axil_awaddr;
   logic [2:0]         s_axil_awprot;
   logic               s_axil_awvalid;
   logic               s_axil_awready;
   logic [WIDTH-1:0]   s_axil_wdata;
   logic [WIDTH/8-1:0] s_axil_wstrb;
   logic               s_axil_wvalid;
   logic               s_axil_wready;
   logic [1:0]         s_axil_bresp;
   logic               s_axil_bvalid;
   logic               s_axil_bready;
   logic [WIDTH-1:0]   s_axil_araddr;
   logic [2:0]         s_axil_arprot;
   logic               s_axil_arvalid;
   logic               s_axil_arready;
   logic [WIDTH-1:0]   s_axil_rdata;
   logic [1:0]         s_axil_rresp;
   logic               s_axil_rvalid;
   logic               s_axil_rready;

   modport master (
      output s_axil_awaddr, s_axil_awprot, s_axil_awvalid,
      input  s_axil_awready,
      output s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
      input  s_axil_wready,
      input  s_axil_bresp, s_axil_bvalid,
      output s_axil_bready,
      output s_axil_araddr, s_axil_arprot, s_axil_arvalid,
      input  s_axil_arready,
      input  s_axil_rdata, s_axil_rresp, s_axil_rvalid,
      output s_axil_rready
   );

   modport slave (
      input  s_axil_awaddr, s_axil_awprot, s_axil_awvalid,
      output s_axil_awready,
      input  s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
      output s_axil_wready,
      output s_axil_bresp, s_axil_bvalid,
      input  s_axil_bready,
      input  s_axil_araddr, s_axil_arprot, s_axil_arvalid,
      output s_axil_arready,
      output s_axil_rdata, s_axil_rresp, s_axil_rvalid,
      input  s_axil_rready
   );
endinterface

// File: rtl/mem_axil_slave.sv
// AXI-Lite responder backed by an on-chip word array. One outstanding write and one
// outstanding read; the two paths run independently. Misses return SLVERR.
module mem_axil_slave #(
   parameter int unsigned     WIDTH       = 32,
   parameter int unsigned     DEPTH_WORDS = 1024,
   parameter logic [WIDTH-1:0] BASE_ADDR  = '0
) (
   input logic             clk,
   input logic             rst_n,
   mem_axil_slave_if.slave bus
);

   localparam int unsigned IdxW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int          NumBytes  = WIDTH / 8;
   localparam logic [WIDTH:0] SpanBytes = (WIDTH + 1)'(4 * DEPTH_WORDS);
   localparam logic [1:0]  RespOkay  = 2'b00;
   localparam logic [1:0]  RespSlverr = 2'b10;

   typedef enum logic [2:0] {StWIdle, StWGotA, StWGotD, StWCommit, StWResp} w_state_e;
   typedef enum logic [0:0] {StRIdle, StRResp} r_state_e;

   logic [WIDTH-1:0] mem [DEPTH_WORDS];

   w_state_e            w_state_q, w_state_d;
   logic [WIDTH-1:0]    awaddr_q, awaddr_d;
   logic [WIDTH-1:0]    wdata_q, wdata_d;
   logic [NumBytes-1:0] wstrb_q, wstrb_d;
   logic                awready_q, awready_d;
   logic                wready_q, wready_d;
   logic                bvalid_q, bvalid_d;
   logic [1:0]          bresp_q, bresp_d;
   logic                mem_we;

   r_state_e            r_state_q, r_state_d;
   logic                arready_q, arready_d;
   logic                rvalid_q, rvalid_d;
   logic [WIDTH-1:0]    rdata_q, rdata_d;
   logic [1:0]          rresp_q, rresp_d;

   logic aw_hs, w_hs, ar_hs;
   assign aw_hs = bus.s_axil_awvalid & awready_q;
   assign w_hs  = bus.s_axil_wvalid & wready_q;
   assign ar_hs = bus.s_axil_arvalid & arready_q;

   // Address decode; the extra top bit of the difference is the borrow for addr < BASE_ADDR.
   logic [WIDTH:0]   w_diff, r_diff;
   logic             w_hit, r_hit;
   logic [IdxW-1:0]  w_idx, r_idx;

   assign w_diff = {1'b0, awaddr_q} - {1'b0, BASE_ADDR};
   assign r_diff = {1'b0, bus.s_axil_araddr} - {1'b0, BASE_ADDR};
   assign w_hit  = !w_diff[WIDTH] && ({1'b0, w_diff[WIDTH-1:0]} < SpanBytes) &&
                   (awaddr_q[1:0] == 2'b00);
   assign r_hit  = !r_diff[WIDTH] && ({1'b0, r_diff[WIDTH-1:0]} < SpanBytes) &&
                   (bus.s_axil_araddr[1:0] == 2'b00);
   assign w_idx  = w_diff[IdxW+1:2];
   assign r_idx  = r_diff[IdxW+1:2];

   logic unused_bits;
   assign unused_bits = ^{bus.s_axil_awprot, bus.s_axil_arprot, w_diff[WIDTH-1:IdxW+2],
                          w_diff[1:0], r_diff[WIDTH-1:IdxW+2], r_diff[1:0]};

   // Write path next-state: latch AW and W in either order, commit, then hold B until accepted.
   always_comb begin
      w_state_d = w_state_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      mem_we    = 1'b0;
      unique case (w_state_q)
         StWIdle: begin
            if (aw_hs) awaddr_d = bus.s_axil_awaddr;
            if (w_hs) begin
               wdata_d = bus.s_axil_wdata;
               wstrb_d = bus.s_axil_wstrb;
            end
            if (aw_hs && w_hs) w_state_d = StWCommit;
            else if (aw_hs)    w_state_d = StWGotA;
            else if (w_hs)     w_state_d = StWGotD;
         end
         StWGotA: begin
            if (w_hs) begin
               wdata_d   = bus.s_axil_wdata;
               wstrb_d   = bus.s_axil_wstrb;
               w_state_d = StWCommit;
            end
         end
         StWGotD: begin
            if (aw_hs) begin
               awaddr_d  = bus.s_axil_awaddr;
               w_state_d = StWCommit;
            end
         end
         StWCommit: begin
            mem_we    = w_hit;
            bresp_d   = w_hit ? RespOkay : RespSlverr;
            bvalid_d  = 1'b1;
            w_state_d = StWResp;
         end
         StWResp: begin
            if (bus.s_axil_bready) begin
               bvalid_d  = 1'b0;
               w_state_d = StWIdle;
            end
         end
         default: w_state_d = StWIdle;
      endcase
      // Readies are registered from the state being entered.
      awready_d = (w_state_d == StWIdle) || (w_state_d == StWGotD);
      wready_d  = (w_state_d == StWIdle) || (w_state_d == StWGotA);
   end

   // Write path state and handshake registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state_q <= StWIdle;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
      end else begin
         w_state_q <= w_state_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
      end
   end

   // Array byte-lane write; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < NumBytes; b++) begin
            if (wstrb_q[b]) mem[w_idx][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

   // Read path next-state: capture data on the AR edge, hold R until accepted.
   always_comb begin
      r_state_d = r_state_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      unique case (r_state_q)
         StRIdle: begin
            if (ar_hs) begin
               rvalid_d  = 1'b1;
               rdata_d   = r_hit ? mem[r_idx] : '0;
               rresp_d   = r_hit ? RespOkay : RespSlverr;
               r_state_d = StRResp;
            end
         end
         StRResp: begin
            if (bus.s_axil_rready) begin
               rvalid_d  = 1'b0;
               r_state_d = StRIdle;
            end
         end
      endcase
      arready_d = (r_state_d == StRIdle);
   end

   // Read path state and handshake registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state_q <= StRIdle;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= 2'b00;
      end else begin
         r_state_q <= r_state_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   assign bus.s_axil_awready = awready_q;
   assign bus.s_axil_wready  = wready_q;
   assign bus.s_axil_bvalid  = bvalid_q;
   assign bus.s_axil_bresp   = bresp_q;
   assign bus.s_axil_arready = arready_q;
   assign bus.s_axil_rvalid  = rvalid_q;
   assign bus.s_axil_rdata   = rdata_q;
   assign bus.s_axil_rresp   = rresp_q;

endmodule

// File: tb/tb_mem_axil_slave.sv
// Self-checking bench for mem_axil_slave: scoreboard queues hold expected B/R responses.
module tb_mem_axil_slave;

   localparam int unsigned DEPTH = 1024;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_axil_slave_if #(.WIDTH(32)) bus ();

   mem_axil_slave #(
      .WIDTH(32),
      .DEPTH_WORDS(DEPTH),
      .BASE_ADDR(32'h0)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   logic [1:0]  exp_b_q [$];
   logic [33:0] exp_r_q [$];
   logic [31:0] model [int unsigned];

   function automatic bit tb_hit(input logic [31:0] a);
      return (a < 32'(4 * DEPTH)) && (a[1:0] == 2'b00);
   endfunction

   function automatic void push_write_exp(input logic [31:0] a, input logic [31:0] d,
                                          input logic [3:0] s);
      logic [31:0] w;
      if (tb_hit(a)) begin
         w = model.exists(a >> 2) ? model[a >> 2] : 32'h0;
         for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
         model[a >> 2] = w;
         exp_b_q.push_back(2'b00);
      end else begin
         exp_b_q.push_back(2'b10);
      end
   endfunction

   function automatic void push_read_exp(input logic [31:0] a);
      if (tb_hit(a)) exp_r_q.push_back({2'b00, model[a >> 2]});
      else           exp_r_q.push_back({2'b10, 32'h0});
   endfunction

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat, output bit to);
      int n;
      to = 1'b0;
      @(negedge clk);
      bus.s_axil_awaddr  = a;
      bus.s_axil_wdata   = d;
      bus.s_axil_wstrb   = s;
      bus.s_axil_awvalid = 1'b1;
      bus.s_axil_wvalid  = 1'b1;
      bus.s_axil_bready  = 1'b1;
      push_write_exp(a, d, s);
      n = 0;
      while (!(bus.s_axil_awready && bus.s_axil_wready) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n == 20) to = 1'b1;
      @(negedge clk);
      bus.s_axil_awvalid = 1'b0;
      bus.s_axil_wvalid  = 1'b0;
      lat = 1;
      while (!bus.s_axil_bvalid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!bus.s_axil_bvalid) to = 1'b1;
      resp = bus.s_axil_bresp;
      @(negedge clk);
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] data,
                          output logic [1:0] resp, output int lat, output bit to);
      int n;
      to = 1'b0;
      @(negedge clk);
      bus.s_axil_araddr  = a;
      bus.s_axil_arvalid = 1'b1;
      bus.s_axil_rready  = 1'b1;
      push_read_exp(a);
      n = 0;
      while (!bus.s_axil_arready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n == 20) to = 1'b1;
      @(negedge clk);
      bus.s_axil_arvalid = 1'b0;
      lat = 1;
      while (!bus.s_axil_rvalid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (!bus.s_axil_rvalid) to = 1'b1;
      data = bus.s_axil_rdata;
      resp = bus.s_axil_rresp;
      @(negedge clk);
   endtask

   task automatic test_reset();
      #23;
      checks++;
      if ({bus.s_axil_awready, bus.s_axil_wready, bus.s_axil_arready} !== 3'b000) begin
         errors++;
         $display("FAIL reset_readies got=%b want=000",
                  {bus.s_axil_awready, bus.s_axil_wready, bus.s_axil_arready});
      end
      checks++;
      if ({bus.s_axil_bvalid, bus.s_axil_rvalid} !== 2'b00) begin
         errors++;
         $display("FAIL reset_valids got=%b want=00", {bus.s_axil_bvalid, bus.s_axil_rvalid});
      end
      checks++;
      if ({bus.s_axil_bresp, bus.s_axil_rresp, bus.s_axil_rdata} !== 36'h0) begin
         errors++;
         $display("FAIL reset_payload got=%h want=0",
                  {bus.s_axil_bresp, bus.s_axil_rresp, bus.s_axil_rdata});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.s_axil_awready, bus.s_axil_wready, bus.s_axil_arready} !== 3'b111) begin
         errors++;
         $display("FAIL idle_readies got=%b want=111",
                  {bus.s_axil_awready, bus.s_axil_wready, bus.s_axil_arready});
      end
   endtask

   task automatic test_write_read();
      logic [1:0] resp, eb; logic [31:0] data; logic [33:0] er; int lat; bit to;
      do_write(32'h10, 32'hDEADBEEF, 4'hF, resp, lat, to);
      eb = exp_b_q.pop_front();
      checks++;
      if (to || resp !== eb) begin
         errors++;
         $display("FAIL wr_basic_bresp got=%b want=%b timeout=%0d", resp, eb, to);
      end
      checks++;
      if (lat !== 2) begin
         errors++;
         $display("FAIL wr_basic_latency got=%0d want=2", lat);
      end
      do_read(32'h10, data, resp, lat, to);
      er = exp_r_q.pop_front();
      checks++;
      if (to || {resp, data} !== er) begin
         errors++;
         $display("FAIL rd_basic got=%h want=%h timeout=%0d", {resp, data}, er, to);
      end
      checks++;
      if (lat !== 1) begin
         errors++;
         $display("FAIL rd_basic_latency got=%0d want=1", lat);
      end
   endtask

   task automatic test_strobe();
      logic [1:0] resp, eb; logic [31:0] data; logic [33:0] er; int lat; bit to;
      logic [31:0] wd [3]; logic [3:0] ws [3];
      wd = '{32'h11223344, 32'hAABBCCDD, 32'h99999999};
      ws = '{4'hF, 4'b0101, 4'h0};
      for (int i = 0; i < 3; i++) begin
         do_write(32'h20, wd[i], ws[i], resp, lat, to);
         eb = exp_b_q.pop_front();
         checks++;
         if (to || resp !== eb) begin
            errors++;
            $display("FAIL strobe_bresp[%0d] got=%b want=%b timeout=%0d", i, resp, eb, to);
         end
         do_read(32'h20, data, resp, lat, to);
         er = exp_r_q.pop_front();
         checks++;
         if (to || {resp, data} !== er) begin
            errors++;
            $display("FAIL strobe_read[%0d] got=%h want=%h timeout=%0d", i, {resp, data}, er, to);
         end
      end
   endtask

   task automatic test_w_before_aw();
      logic [1:0] resp, eb; logic [31:0] data; logic [33:0] er; int lat; bit to;
      @(negedge clk);
      bus.s_axil_wdata  = 32'hCAFEF00D;
      bus.s_axil_wstrb  = 4'hF;
      bus.s_axil_wvalid = 1'b1;
      bus.s_axil_bready = 1'b1;
      push_write_exp(32'h40, 32'hCAFEF00D, 4'hF);
      @(negedge clk);
      bus.s_axil_wvalid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if ({bus.s_axil_awready, bus.s_axil_wready, bus.s_axil_bvalid} !== 3'b100) begin
            errors++;
            $display("FAIL w_first_readies[%0d] got=%b want=100", c,
                     {bus.s_axil_awready, bus.s_axil_wready, bus.s_axil_bvalid});
         end
         if (c == 2) begin
            bus.s_axil_awaddr  = 32'h40;
            bus.s_axil_awvalid = 1'b1;
         end
         @(negedge clk);
      end
      bus.s_axil_awvalid = 1'b0;
      checks++;
      if (bus.s_axil_bvalid !== 1'b0) begin
         errors++;
         $display("FAIL w_first_commit_bvalid got=%b want=0", bus.s_axil_bvalid);
      end
      @(negedge clk);
      eb = exp_b_q.pop_front();
      checks++;
      if ({bus.s_axil_bvalid, bus.s_axil_bresp} !== {1'b1, eb}) begin
         errors++;
         $display("FAIL w_first_bresp got=%b want=%b", {bus.s_axil_bvalid, bus.s_axil_bresp},
                  {1'b1, eb});
      end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if (bus.s_axil_bvalid !== 1'b0) begin
            errors++;
            $display("FAIL w_first_single_b[%0d] got=%b want=0", c, bus.s_axil_bvalid);
         end
      end
      do_read(32'h40, data, resp, lat, to);
      er = exp_r_q.pop_front();
      checks++;
      if (to || {resp, data} !== er) begin
         errors++;
         $display("FAIL w_first_read got=%h want=%h timeout=%0d", {resp, data}, er, to);
      end
   endtask

   task automatic test_errors();
      logic [1:0] resp, eb; logic [31:0] data; logic [33:0] er; int lat; bit to;
      logic [31:0] ra [4];
      do_write(32'(4 * DEPTH - 4), 32'h5A5A5A5A, 4'hF, resp, lat, to);
      eb = exp_b_q.pop_front();
      checks++;
      if (to || resp !== eb) begin
         errors++;
         $display("FAIL err_last_word_bresp got=%b want=%b timeout=%0d", resp, eb, to);
      end
      do_write(32'h13, 32'h0BADF00D, 4'hF, resp, lat, to);
      eb = exp_b_q.pop_front();
      checks++;
      if (to || resp !== eb) begin
         errors++;
         $display("FAIL err_misaligned_bresp got=%b want=%b timeout=%0d", resp, eb, to);
      end
      ra = '{32'(4 * DEPTH), 32'(4 * DEPTH - 4), 32'h12, 32'h10};
      for (int i = 0; i < 4; i++) begin
         do_read(ra[i], data, resp, lat, to);
         er = exp_r_q.pop_front();
         checks++;
         if (to || {resp, data} !== er) begin
            errors++;
            $display("FAIL err_read[%h] got=%h want=%h timeout=%0d", ra[i], {resp, data}, er, to);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [1:0] resp, eb; logic [31:0] data; logic [33:0] er; int lat; bit to;
      @(negedge clk);
      bus.s_axil_awaddr  = 32'h44;
      bus.s_axil_wdata   = 32'h13579BDF;
      bus.s_axil_wstrb   = 4'hF;
      bus.s_axil_awvalid = 1'b1;
      bus.s_axil_wvalid  = 1'b1;
      bus.s_axil_bready  = 1'b0;
      push_write_exp(32'h44, 32'h13579BDF, 4'hF);
      @(negedge clk);
      bus.s_axil_awvalid = 1'b0;
      bus.s_axil_wvalid  = 1'b0;
      @(negedge clk);
      eb = exp_b_q.pop_front();
      for (int c = 0; c < 5; c++) begin
         checks++;
         if ({bus.s_axil_bvalid, bus.s_axil_bresp, bus.s_axil_awready, bus.s_axil_wready} !==
             {1'b1, eb, 2'b00}) begin
            errors++;
            $display("FAIL bp_write_hold[%0d] got=%b want=%b", c,
                     {bus.s_axil_bvalid, bus.s_axil_bresp, bus.s_axil_awready, bus.s_axil_wready},
                     {1'b1, eb, 2'b00});
         end
         @(negedge clk);
      end
      bus.s_axil_bready = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.s_axil_bvalid, bus.s_axil_awready, bus.s_axil_wready} !== 3'b011) begin
         errors++;
         $display("FAIL bp_write_release got=%b want=011",
                  {bus.s_axil_bvalid, bus.s_axil_awready, bus.s_axil_wready});
      end
      bus.s_axil_araddr  = 32'h44;
      bus.s_axil_arvalid = 1'b1;
      bus.s_axil_rready  = 1'b0;
      push_read_exp(32'h44);
      @(negedge clk);
      bus.s_axil_arvalid = 1'b0;
      er = exp_r_q.pop_front();
      for (int c = 0; c < 5; c++) begin
         checks++;
         if ({bus.s_axil_rvalid, bus.s_axil_arready, bus.s_axil_rresp, bus.s_axil_rdata} !==
             {2'b10, er}) begin
            errors++;
            $display("FAIL bp_read_hold[%0d] got=%h want=%h", c,
                     {bus.s_axil_rvalid, bus.s_axil_arready, bus.s_axil_rresp, bus.s_axil_rdata},
                     {2'b10, er});
         end
         @(negedge clk);
      end
      bus.s_axil_rready = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.s_axil_rvalid, bus.s_axil_arready} !== 2'b01) begin
         errors++;
         $display("FAIL bp_read_release got=%b want=01", {bus.s_axil_rvalid, bus.s_axil_arready});
      end
      do_read(32'h44, data, resp, lat, to);
      er = exp_r_q.pop_front();
      checks++;
      if (to || {resp, data} !== er) begin
         errors++;
         $display("FAIL bp_next_read got=%h want=%h timeout=%0d", {resp, data}, er, to);
      end
   endtask

   task automatic test_rw_collision();
      logic [1:0] resp, eb; logic [31:0] data, old; logic [33:0] er; int lat; bit to;
      do_write(32'h80, 32'h01020304, 4'hF, resp, lat, to);
      eb = exp_b_q.pop_front();
      checks++;
      if (to || resp !== eb) begin
         errors++;
         $display("FAIL coll_prewrite_bresp got=%b want=%b timeout=%0d", resp, eb, to);
      end
      old = model[32'h80 >> 2];
      @(negedge clk);
      checks++;
      if ({bus.s_axil_awready, bus.s_axil_wready, bus.s_axil_arready} !== 3'b111) begin
         errors++;
         $display("FAIL coll_idle got=%b want=111",
                  {bus.s_axil_awready, bus.s_axil_wready, bus.s_axil_arready});
      end
      bus.s_axil_awaddr  = 32'h80;
      bus.s_axil_wdata   = 32'hF0E0D0C0;
      bus.s_axil_wstrb   = 4'hF;
      bus.s_axil_awvalid = 1'b1;
      bus.s_axil_wvalid  = 1'b1;
      bus.s_axil_bready  = 1'b1;
      push_write_exp(32'h80, 32'hF0E0D0C0, 4'hF);
      exp_r_q.push_back({2'b00, old});
      @(negedge clk);
      // Write is now in its commit cycle; this read handshakes on the commit edge.
      bus.s_axil_awvalid = 1'b0;
      bus.s_axil_wvalid  = 1'b0;
      bus.s_axil_araddr  = 32'h80;
      bus.s_axil_arvalid = 1'b1;
      bus.s_axil_rready  = 1'b1;
      @(negedge clk);
      bus.s_axil_arvalid = 1'b0;
      er = exp_r_q.pop_front();
      eb = exp_b_q.pop_front();
      checks++;
      if ({bus.s_axil_rvalid, bus.s_axil_rresp, bus.s_axil_rdata} !== {1'b1, er}) begin
         errors++;
         $display("FAIL coll_old_value got=%h want=%h",
                  {bus.s_axil_rvalid, bus.s_axil_rresp, bus.s_axil_rdata}, {1'b1, er});
      end
      checks++;
      if ({bus.s_axil_bvalid, bus.s_axil_bresp} !== {1'b1, eb}) begin
         errors++;
         $display("FAIL coll_bresp got=%b want=%b", {bus.s_axil_bvalid, bus.s_axil_bresp},
                  {1'b1, eb});
      end
      @(negedge clk);
      do_read(32'h80, data, resp, lat, to);
      er = exp_r_q.pop_front();
      checks++;
      if (to || {resp, data} !== er) begin
         errors++;
         $display("FAIL coll_new_value got=%h want=%h timeout=%0d", {resp, data}, er, to);
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0] resp; logic [31:0] data; logic [33:0] er; int lat; bit to;
      @(negedge clk);
      bus.s_axil_araddr  = 32'h10;
      bus.s_axil_arvalid = 1'b1;
      bus.s_axil_rready  = 1'b0;
      @(negedge clk);
      bus.s_axil_arvalid = 1'b0;
      bus.s_axil_awaddr  = 32'h10;
      bus.s_axil_awvalid = 1'b1;
      @(negedge clk);
      bus.s_axil_awvalid = 1'b0;
      checks++;
      if ({bus.s_axil_awready, bus.s_axil_wready, bus.s_axil_rvalid, bus.s_axil_arready} !==
          4'b0110) begin
         errors++;
         $display("FAIL midrst_setup got=%b want=0110",
                  {bus.s_axil_awready, bus.s_axil_wready, bus.s_axil_rvalid, bus.s_axil_arready});
      end
      #2;
      rst_n = 1'b0;
      bus.s_axil_wdata  = 32'h0BADF00D;
      bus.s_axil_wstrb  = 4'hF;
      bus.s_axil_wvalid = 1'b1;
      #1;
      checks++;
      if ({bus.s_axil_awready, bus.s_axil_wready, bus.s_axil_arready,
           bus.s_axil_bvalid, bus.s_axil_rvalid} !== 5'b00000) begin
         errors++;
         $display("FAIL midrst_async got=%b want=00000",
                  {bus.s_axil_awready, bus.s_axil_wready, bus.s_axil_arready,
                   bus.s_axil_bvalid, bus.s_axil_rvalid});
      end
      repeat (2) @(negedge clk);
      bus.s_axil_wvalid = 1'b0;
      bus.s_axil_rready = 1'b1;
      bus.s_axil_bready = 1'b1;
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if ({bus.s_axil_bvalid, bus.s_axil_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL midrst_stray[%0d] got=%b want=00", c,
                     {bus.s_axil_bvalid, bus.s_axil_rvalid});
         end
      end
      do_read(32'h10, data, resp, lat, to);
      er = exp_r_q.pop_front();
      checks++;
      if (to || {resp, data} !== er) begin
         errors++;
         $display("FAIL midrst_word got=%h want=%h timeout=%0d", {resp, data}, er, to);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin
      bus.s_axil_awaddr  = '0;
      bus.s_axil_awprot  = 3'b000;
      bus.s_axil_awvalid = 1'b0;
      bus.s_axil_wdata   = '0;
      bus.s_axil_wstrb   = '0;
      bus.s_axil_wvalid  = 1'b0;
      bus.s_axil_bready  = 1'b1;
      bus.s_axil_araddr  = '0;
      bus.s_axil_arprot  = 3'b000;
      bus.s_axil_arvalid = 1'b0;
      bus.s_axil_rready  = 1'b1;
      test_reset();
      test_write_read();
      test_strobe();
      test_w_before_aw();
      test_errors();
      test_backpressure();
      test_rw_collision();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
